// File: rtl/rest_sum_checker.sv
// On-chip sweep driver and checker for the 4-bit restSum adder/subtractor.
// Walks all 1024 operand vectors, compares against a reference, keeps stats.
module rest_sum_checker #(
  parameter int SETTLE       = 1,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  dut_a,
  output logic [3:0]  dut_b,
  output logic        dut_ci,
  output logic        dut_ctrl,
  input  logic [4:0]  dut_res,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [10:0] err_count,
  output logic [9:0]  first_fail_vec,
  output logic [4:0]  first_fail_got,
  output logic [4:0]  first_fail_exp
);

  localparam int HW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [HW-1:0] HMAX = HW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [9:0]    vec;
  logic [HW-1:0] hold;
  logic [3:0]    b_eff;
  logic [4:0]    exp_res;
  logic          mis;
  logic          last;

  assign dut_a    = vec[9:6];
  assign dut_b    = vec[5:2];
  assign dut_ci   = vec[1];
  assign dut_ctrl = vec[0];

  // subtract is A + ~B + Ci, so Ci=1 gives the two's complement form
  always_comb begin
    b_eff   = vec[0] ? ~vec[5:2] : vec[5:2];
    exp_res = {1'b0, vec[9:6]} + {1'b0, b_eff}
            + {4'b0000, vec[1]};
    mis     = (dut_res != exp_res);
    last    = (vec == 10'h3FF) || (mis && STOP_ON_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      vec            <= '0;
      hold           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= '0;
      first_fail_got <= '0;
      first_fail_exp <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RUN;
            vec            <= '0;
            hold           <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
            first_fail_got <= '0;
            first_fail_exp <= '0;
          end
        end
        RUN: begin
          if (hold == HMAX) begin
            hold <= '0;
            if (mis) begin
              err_count <= err_count + 11'd1;
              if (err_count == '0) begin
                first_fail_vec <= vec;
                first_fail_got <= dut_res;
                first_fail_exp <= exp_res;
              end
            end
            // vec is left untouched on exit so dut_* show the final vector
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !mis;
            end else begin
              vec <= vec + 10'd1;
            end
          end else begin
            hold <= hold + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rest_sum_checker.sv
// Scoreboard bench for rest_sum_checker: three configurations driving a
// behavioural restSum with injectable faults, checked against a sweep model.
module tb_rest_sum_checker;

  typedef struct {
    int inst;
    int errs;
    int fvec;
    int fgot;
    int fexp;
    int cycles;
    int lastv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_w [3];
  logic [3:0]  da [3];
  logic [3:0]  db [3];
  logic        dci [3];
  logic        dct [3];
  logic [4:0]  res [3];
  logic        busy_w [3];
  logic        done_w [3];
  logic        pass_w [3];
  logic [10:0] ec [3];
  logic [9:0]  ffv [3];
  logic [4:0]  ffg [3];
  logic [4:0]  ffe [3];
  logic [4:0]  am [3];
  logic [4:0]  om [3];
  logic [4:0]  xm [3];

  int   nchk = 0;
  int   nerr = 0;
  int   bcnt [3];
  logic done_d [3];
  exp_t q [$];

  always #5 clk = ~clk;

  // behavioural restSum with stuck/invert masks on the result bits
  function automatic logic [4:0] rs(input logic [3:0] a, b,
                                    input logic ci, ct,
                                    input logic [4:0] ma, mo, mx);
    int s;
    s = int'(a) + (ct ? 15 - int'(b) : int'(b)) + int'(ci);
    return ((5'(s) & ma) | mo) ^ mx;
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g
    rest_sum_checker #(
      .SETTLE      ((i == 2) ? 3 : 1),
      .STOP_ON_FAIL(i == 1)
    ) u (
      .clk           (clk),
      .rst           (rst),
      .start         (start_w[i]),
      .dut_a         (da[i]),
      .dut_b         (db[i]),
      .dut_ci        (dci[i]),
      .dut_ctrl      (dct[i]),
      .dut_res       (res[i]),
      .busy          (busy_w[i]),
      .done          (done_w[i]),
      .pass          (pass_w[i]),
      .err_count     (ec[i]),
      .first_fail_vec(ffv[i]),
      .first_fail_got(ffg[i]),
      .first_fail_exp(ffe[i])
    );
    assign res[i] = rs(da[i], db[i], dci[i], dct[i],
                       am[i], om[i], xm[i]);
  end

  function automatic int settle(int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic int curvec(int i);
    return int'({da[i], db[i], dci[i], dct[i]});
  endfunction

  task automatic chk(string nm, int got, int expv);
    nchk++;
    if (got != expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  // whole-sweep reference: what a finished run should report
  function automatic exp_t model(int i, logic [4:0] ma, mo, mx);
    exp_t e;
    e = '{default: 0};
    e.inst = i;
    for (int v = 0; v < 1024; v++) begin
      int a, b, ci, ct, gd, got;
      a  = v >> 6;
      b  = (v >> 2) & 15;
      ci = (v >> 1) & 1;
      ct = v & 1;
      gd = (a + (ct != 0 ? 15 - b : b) + ci) % 32;
      got = ((gd & int'(ma)) | int'(mo)) ^ int'(mx);
      e.lastv  = v;
      e.cycles = (v + 1) * settle(i);
      if (got != gd) begin
        if (e.errs == 0) begin
          e.fvec = v;
          e.fgot = got;
          e.fexp = gd;
        end
        e.errs++;
        if (i == 1) break;
      end
    end
    return e;
  endfunction

  task automatic chk_zero(int i, string tag);
    chk({tag, "_busy"}, busy_w[i], 0);
    chk({tag, "_done"}, done_w[i], 0);
    chk({tag, "_pass"}, pass_w[i], 0);
    chk({tag, "_err"}, ec[i], 0);
    chk({tag, "_ffvec"}, ffv[i], 0);
    chk({tag, "_ffgot"}, ffg[i], 0);
    chk({tag, "_ffexp"}, ffe[i], 0);
    chk({tag, "_vec"}, curvec(i), 0);
  endtask

  // monitor: vector sequencing every cycle, scoreboard pop on done rising
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        bcnt[i]   = 0;
        done_d[i] = 1'b0;
      end else begin
        if (busy_w[i]) begin
          chk("vec_seq", curvec(i), bcnt[i] / settle(i));
          bcnt[i]++;
        end
        if (done_w[i] && !done_d[i]) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_inst", i, e.inst);
            chk("sb_err_count", ec[i], e.errs);
            chk("sb_pass", pass_w[i], int'(e.errs == 0));
            chk("sb_ff_vec", ffv[i], e.fvec);
            chk("sb_ff_got", ffg[i], e.fgot);
            chk("sb_ff_exp", ffe[i], e.fexp);
            chk("sb_busy_cycles", bcnt[i], e.cycles);
            chk("sb_held_vec", curvec(i), e.lastv);
            chk("sb_busy_low", busy_w[i], 0);
          end
          bcnt[i] = 0;
        end
        done_d[i] = done_w[i];
      end
    end
  end

  // mode 0: plain sweep, 1: extra start mid-sweep, 2: rst at vec 300
  task automatic run(int i, logic [4:0] ma, mo, mx, int mode);
    int n;
    am[i] = ma;
    om[i] = mo;
    xm[i] = mx;
    if (mode != 2) q.push_back(model(i, ma, mo, mx));
    @(posedge clk); #1 start_w[i] = 1'b1;
    @(posedge clk); #1 start_w[i] = 1'b0;
    n = 0;
    if (mode == 1) begin
      repeat (500) @(posedge clk);
      #1 start_w[i] = 1'b1;
      @(posedge clk); #1 start_w[i] = 1'b0;
    end
    if (mode == 2) begin
      while (curvec(i) != 300 && n < 2000) begin
        @(posedge clk); #1;
        n++;
      end
      chk("reach_vec300", curvec(i), 300);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_zero(i, "abort");
      @(posedge clk); #1;
      chk("abort_no_done", done_w[i], 0);
      chk("abort_idle", busy_w[i], 0);
      return;
    end
    while (!done_w[i] && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_in_time", done_w[i], 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic [4:0] rnd5(int k);
    logic [4:0] r;
    r = 5'($urandom_range(0, 31));
    for (int j = 0; j < k; j++) r = r & 5'($urandom_range(0, 31));
    return r;
  endfunction

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_w[i] = 1'b0;
      am[i] = 5'h1F;
      om[i] = 5'h00;
      xm[i] = 5'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk_zero(i, "reset");
    rst = 1'b0;

    run(0, 5'h1F, 5'h00, 5'h00, 0);
    chk("ok_pass", pass_w[0], 1);
    chk("ok_err", ec[0], 0);

    run(0, 5'h1E, 5'h00, 5'h00, 0);
    chk("s1_err", ec[0], 512);
    chk("s1_pass", pass_w[0], 0);
    chk("s1_ffvec", ffv[0], 1);
    chk("s1_ffgot", ffg[0], 'h0E);
    chk("s1_ffexp", ffe[0], 'h0F);

    run(0, 5'h1F, 5'h00, 5'h10, 0);
    chk("c0_err", ec[0], 1024);
    chk("c0_ffvec", ffv[0], 0);
    chk("c0_ffgot", ffg[0], 'h10);
    chk("c0_ffexp", ffe[0], 'h00);

    for (int k = 0; k < 4; k++)
      run(0, ~rnd5(2), rnd5(2), rnd5(2), 0);

    run(1, 5'h1E, 5'h00, 5'h00, 0);
    chk("stop_err", ec[1], 1);
    chk("stop_a", da[1], 0);
    chk("stop_b", db[1], 0);
    chk("stop_ctrl", dct[1], 1);
    for (int k = 0; k < 2; k++)
      run(1, ~rnd5(2), rnd5(3), rnd5(3), 0);

    run(2, 5'h1F, 5'h00, 5'h00, 1);
    chk("s3_pass", pass_w[2], 1);
    run(2, ~rnd5(2), rnd5(2), rnd5(2), 0);

    run(0, 5'h1F, 5'h00, 5'h00, 2);
    run(0, 5'h1F, 5'h00, 5'h00, 0);
    chk("rerun_pass", pass_w[0], 1);

    chk("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
